// File: rtl/uart_tx_fifo_if.sv
// Host-push and Transmitter-handshake signals of uart_tx_fifo.
// The overflow flag exists only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(parameter int ADDR_W = 4);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic              overflow;

  modport master (output wr_en, wr_data, tx_busy,
                  input  full, empty, level, tx_data, tx_start, overflow);
  modport slave  (input  wr_en, wr_data, tx_busy,
                  output full, empty, level, tx_data, tx_start, overflow);
`else
  modport master (output wr_en, wr_data, tx_busy,
                  input  full, empty, level, tx_data, tx_start);
  modport slave  (input  wr_en, wr_data, tx_busy,
                  output full, empty, level, tx_data, tx_start);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART Transmitter, one frame at a time via transmit/busy.
// Optional sticky write-while-full flag: define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              pop, push, is_full;

  assign is_full = (level == FULL_LVL);
  assign pop     = (state == IDLE) && (level != '0) && !bus.tx_busy;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign push    = bus.wr_en && (!is_full || pop);

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      state    <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: ;
      endcase
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data  <= mem[rd_ptr];
          tx_start <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH:    state <= WAIT_BUSY;
        WAIT_BUSY: if (bus.tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!bus.tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf;
  always_ff @(posedge clk) begin
    if (rst)                                 ovf <= 1'b0;
    else if (bus.wr_en && is_full && !pop)   ovf <= 1'b1;
  end
  assign bus.overflow = ovf;
`endif

  assign bus.full     = is_full;
  assign bus.empty    = (level == '0);
  assign bus.level    = level;
  assign bus.tx_data  = tx_data;
  assign bus.tx_start = tx_start;
endmodule
